// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared command/state encodings for the score command arbiter
package scoreboard_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_INCR = 2'b01,
        CMD_DECR = 2'b10,
        CMD_CLR  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_HOLDOFF = 2'b10
    } arb_state_t;

    localparam int CLR_CNT_W = 3;

endpackage

// File: rtl/score_cmd_arbiter_rr.sv
// rtl/score_cmd_arbiter_rr.sv - round-robin pick with registered rotate pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk_100Hz,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    input  logic [IDX_W-1:0]   i_adv_idx,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    logic [IDX_W-1:0] r_ptr;

    // First valid request scanning upward from the pointer, wrapping around.
    always_comb begin
        int w_idx;
        o_grant_any = 1'b0;
        o_grant_idx = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!o_grant_any && i_req[w_idx]) begin
                o_grant_any = 1'b1;
                o_grant_idx = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (i_adv_idx == IDX_W'(NUM_REQ - 1)) ? '0 : i_adv_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/score_cmd_arbiter.sv
// rtl/score_cmd_arbiter.sv - round-robin score command arbiter with clear lock and saturation guard
// Optional undo of the last incr/decr: define SCORE_UNDO_EN.
import scoreboard_pkg::*;

module score_cmd_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int CLR_PRESSES = 5
) (
    input  logic                   clk_100Hz,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [2*NUM_REQ-1:0]   i_req_cmd,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic                   i_score_at_max,
    input  logic                   i_score_at_min,
`ifdef SCORE_UNDO_EN
    input  logic                   i_undo_req,
`endif
    output logic                   o_incr_out,
    output logic                   o_decr_out,
    output logic                   o_clear_out,
    output logic                   o_cmd_dropped,
    output logic [CLR_CNT_W-1:0]   o_clr_count
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_grant_any;
    logic             w_advance;
    cmd_t             w_cmd;

`ifdef SCORE_UNDO_EN
    logic r_grant_is_req;
    logic r_undo_valid;
    logic r_undo_was_incr;
    assign w_advance = (r_state == ST_ISSUE) && r_grant_is_req;
`else
    assign w_advance = (r_state == ST_ISSUE);
`endif

    assign w_cmd = cmd_t'(i_req_cmd[2*w_grant_idx +: 2]);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk_100Hz   (clk_100Hz),
        .reset       (reset),
        .i_req       (i_req_valid),
        .i_advance   (w_advance),
        .i_adv_idx   (r_grant_idx),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant_idx   <= '0;
            o_req_ready   <= '0;
            o_incr_out    <= 1'b0;
            o_decr_out    <= 1'b0;
            o_clear_out   <= 1'b0;
            o_cmd_dropped <= 1'b0;
            o_clr_count   <= '0;
`ifdef SCORE_UNDO_EN
            r_grant_is_req  <= 1'b0;
            r_undo_valid    <= 1'b0;
            r_undo_was_incr <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef SCORE_UNDO_EN
                    if (i_undo_req) begin
                        // Undo rides the same issue/holdoff slot but acknowledges no requester.
                        r_state        <= ST_ISSUE;
                        r_grant_is_req <= 1'b0;
                        r_undo_valid   <= 1'b0;
                        if (r_undo_valid && r_undo_was_incr && !i_score_at_min)
                            o_decr_out <= 1'b1;
                        else if (r_undo_valid && !r_undo_was_incr && !i_score_at_max)
                            o_incr_out <= 1'b1;
                        else
                            o_cmd_dropped <= 1'b1;
                    end else
`endif
                    if (w_grant_any) begin
                        r_state     <= ST_ISSUE;
                        r_grant_idx <= w_grant_idx;
                        o_req_ready <= NUM_REQ'(1) << w_grant_idx;
`ifdef SCORE_UNDO_EN
                        r_grant_is_req <= 1'b1;
`endif
                        case (w_cmd)
                            CMD_INCR: begin
                                o_clr_count <= '0;
                                if (i_score_at_max) begin
                                    o_cmd_dropped <= 1'b1;
                                end else begin
                                    o_incr_out <= 1'b1;
`ifdef SCORE_UNDO_EN
                                    r_undo_valid    <= 1'b1;
                                    r_undo_was_incr <= 1'b1;
`endif
                                end
                            end
                            CMD_DECR: begin
                                o_clr_count <= '0;
                                if (i_score_at_min) begin
                                    o_cmd_dropped <= 1'b1;
                                end else begin
                                    o_decr_out <= 1'b1;
`ifdef SCORE_UNDO_EN
                                    r_undo_valid    <= 1'b1;
                                    r_undo_was_incr <= 1'b0;
`endif
                                end
                            end
                            CMD_CLR: begin
                                if (o_clr_count == CLR_CNT_W'(CLR_PRESSES - 1)) begin
                                    o_clear_out <= 1'b1;
                                    o_clr_count <= '0;
`ifdef SCORE_UNDO_EN
                                    r_undo_valid <= 1'b0;
`endif
                                end else begin
                                    o_clr_count <= o_clr_count + CLR_CNT_W'(1);
                                end
                            end
                            default: o_cmd_dropped <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    r_state       <= ST_HOLDOFF;
                    o_req_ready   <= '0;
                    o_incr_out    <= 1'b0;
                    o_decr_out    <= 1'b0;
                    o_clear_out   <= 1'b0;
                    o_cmd_dropped <= 1'b0;
                end
                ST_HOLDOFF: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
